// File: rtl/musa_pkg.sv
// Shared MUSA core constants used by the return-address stack.
package musa_pkg;

  // Overflow handling modes for the return-address stack
  localparam int unsigned RAS_OVF_SATURATE = 0;
  localparam int unsigned RAS_OVF_WRAP     = 1;

  // Default program-counter width
  localparam int unsigned MUSA_PC_W = 18;

endpackage

// File: rtl/ras_storage.sv
// Return-address stack storage: DEPTH x ADDR_W array with one synchronous
// write port and one asynchronous read port. Contents are not reset.
// Ports:
//   clk    in  core clock
//   we     in  write enable
//   waddr  in  write index
//   wdata  in  write data
//   raddr  in  read index
//   rdata  out combinational read data
module ras_storage #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read port
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Parametrised return-address stack: saves the return PC on CALL (push) and
// supplies it on RET (pop). Circular storage indexed by a top pointer, with
// occupancy status, sticky overflow/underflow flags, flush and push+pop replace.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   push, pop, flush      stack operations (flush has priority)
//   err_clr               clear sticky error flags
//   read_pc               return address to push
//   write_pc              current top entry, 0 when empty
//   empty, full, count    occupancy status
//   overflow, underflow   sticky error flags
module return_addr_stack
  import musa_pkg::*;
#(
  parameter int unsigned ADDR_W   = MUSA_PC_W,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned OVF_MODE = RAS_OVF_SATURATE,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] read_pc,
  output logic [ADDR_W-1:0] write_pc,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [PTR_W-1:0]  top_q, top_d, top_m1;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;

  // Index of the current top entry (wraps modulo DEPTH)
  assign top_m1 = top_q - PTR_W'(1);

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign write_pc  = empty ? '0 : rdata;

  ras_storage #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (read_pc),
    .raddr (top_m1),
    .rdata (rdata)
  );

  // Next-state logic: flush > push/pop; flags set this cycle win over err_clr
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = top_q;

    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (flush) begin
      top_d   = '0;
      count_d = '0;
    end else if (push && pop) begin
      if (!empty) begin
        // Replace the top entry in place
        we    = 1'b1;
        waddr = top_m1;
      end else begin
        unf_d   = 1'b1;
        we      = 1'b1;
        top_d   = top_q + PTR_W'(1);
        count_d = CNT_W'(1);
      end
    end else if (push) begin
      if (!full) begin
        we      = 1'b1;
        top_d   = top_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
        if (OVF_MODE == RAS_OVF_WRAP) begin
          // Overwrite the oldest entry; count stays at DEPTH
          we    = 1'b1;
          top_d = top_q + PTR_W'(1);
        end
      end
    end else if (pop) begin
      if (!empty) begin
        top_d   = top_m1;
        count_d = count_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: default instance (depth 8, saturate)
// plus depth-4 saturate and depth-4 wrap instances sharing one stimulus bus.
module tb_return_addr_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push, pop, flush, err_clr;
  logic [17:0] read_pc;

  logic [17:0] wp8, wps, wpw;
  logic        emp8, emps, empw, ful8, fuls, fulw;
  logic [3:0]  cnt8;
  logic [2:0]  cnts, cntw;
  logic        ovf8, ovfs, ovfw, unf8, unfs, unfw;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  return_addr_stack #(.ADDR_W(18), .DEPTH(8), .OVF_MODE(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .read_pc(read_pc), .write_pc(wp8), .empty(emp8),
    .full(ful8), .count(cnt8), .overflow(ovf8), .underflow(unf8));

  return_addr_stack #(.ADDR_W(18), .DEPTH(4), .OVF_MODE(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .read_pc(read_pc), .write_pc(wps), .empty(emps),
    .full(fuls), .count(cnts), .overflow(ovfs), .underflow(unfs));

  return_addr_stack #(.ADDR_W(18), .DEPTH(4), .OVF_MODE(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .read_pc(read_pc), .write_pc(wpw), .empty(empw),
    .full(fulw), .count(cntw), .overflow(ovfw), .underflow(unfw));

  // Apply one cycle of stimulus, sample 1 time unit after the edge
  task automatic step(input logic pu, input logic po, input logic fl,
                      input logic ec, input logic [17:0] pc);
    push = pu; pop = po; flush = fl; err_clr = ec; read_pc = pc;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; read_pc = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; read_pc = '0;
    #12;
    n_checks++; if (cnt8 !== 4'd0) begin n_fail++; $display("FAIL reset_count8 got=%0d exp=0", cnt8); end
    n_checks++; if (emp8 !== 1'b1 || ful8 !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full8 got=%b%b exp=10", emp8, ful8); end
    n_checks++; if (wp8 !== 18'h0) begin n_fail++; $display("FAIL reset_write_pc8 got=%h exp=0", wp8); end
    n_checks++; if ({ovf8, unf8, ovfs, unfs, ovfw, unfw} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=000000", {ovf8, unf8, ovfs, unfs, ovfw, unfw}); end
    n_checks++; if (cnts !== 3'd0 || cntw !== 3'd0) begin n_fail++; $display("FAIL reset_count4 got=%0d/%0d exp=0/0", cnts, cntw); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop();
    step(1, 0, 0, 0, 18'h00010);
    step(1, 0, 0, 0, 18'h00020);
    step(1, 0, 0, 0, 18'h00030);
    n_checks++; if (cnt8 !== 4'd3) begin n_fail++; $display("FAIL pp_count got=%0d exp=3", cnt8); end
    n_checks++; if (wp8 !== 18'h00030) begin n_fail++; $display("FAIL pp_top got=%h exp=00030", wp8); end
    pop = 1'b1; #1;
    n_checks++; if (wp8 !== 18'h00030) begin n_fail++; $display("FAIL pp_pop_value got=%h exp=00030", wp8); end
    step(0, 1, 0, 0, '0);
    n_checks++; if (wp8 !== 18'h00020 || cnt8 !== 4'd2) begin n_fail++; $display("FAIL pp_after_pop got=%h/%0d exp=00020/2", wp8, cnt8); end
    step(0, 0, 1, 1, '0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 18'(i));
    n_checks++; if (fuls !== 1'b1 || cnts !== 3'd4) begin n_fail++; $display("FAIL sat_full got=%b/%0d exp=1/4", fuls, cnts); end
    n_checks++; if (wps !== 18'd4) begin n_fail++; $display("FAIL sat_top got=%0d exp=4", wps); end
    n_checks++; if (ovfs !== 1'b1) begin n_fail++; $display("FAIL sat_overflow got=%b exp=1", ovfs); end
    n_checks++; if (ovf8 !== 1'b0 || cnt8 !== 4'd5 || ful8 !== 1'b0) begin n_fail++; $display("FAIL d8_no_ovf got=%b/%0d/%b exp=0/5/0", ovf8, cnt8, ful8); end
    n_checks++; if (wpw !== 18'd5 || cntw !== 3'd4 || ovfw !== 1'b1) begin n_fail++; $display("FAIL wrap_top got=%0d/%0d/%b exp=5/4/1", wpw, cntw, ovfw); end
    for (int i = 5; i >= 2; i--) begin
      n_checks++; if (wpw !== 18'(i)) begin n_fail++; $display("FAIL wrap_pop got=%0d exp=%0d", wpw, i); end
      step(0, 1, 0, 0, '0);
    end
    n_checks++; if (empw !== 1'b1 || wpw !== 18'd0) begin n_fail++; $display("FAIL wrap_empty got=%b/%h exp=1/0", empw, wpw); end
    n_checks++; if (cnt8 !== 4'd1 || wp8 !== 18'd1) begin n_fail++; $display("FAIL d8_after_pops got=%0d/%h exp=1/1", cnt8, wp8); end
    step(0, 0, 1, 1, '0);
    n_checks++; if (ovfs !== 1'b0 || ovfw !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b/%b exp=0/0", ovfs, ovfw); end
  endtask

  task automatic test_underflow();
    step(0, 1, 0, 0, '0);
    n_checks++; if (unf8 !== 1'b1 || cnt8 !== 4'd0 || wp8 !== 18'h0) begin n_fail++; $display("FAIL unf_set got=%b/%0d/%h exp=1/0/0", unf8, cnt8, wp8); end
    step(0, 0, 0, 1, '0);
    n_checks++; if (unf8 !== 1'b0) begin n_fail++; $display("FAIL unf_clr got=%b exp=0", unf8); end
    step(0, 1, 0, 1, '0);
    n_checks++; if (unf8 !== 1'b1) begin n_fail++; $display("FAIL unf_set_wins got=%b exp=1", unf8); end
    step(0, 0, 0, 1, '0);
  endtask

  task automatic test_replace();
    step(1, 0, 0, 0, 18'h00100);
    step(1, 1, 0, 0, 18'h00200);
    n_checks++; if (cnt8 !== 4'd1 || wp8 !== 18'h00200) begin n_fail++; $display("FAIL repl got=%0d/%h exp=1/00200", cnt8, wp8); end
    n_checks++; if (ovf8 !== 1'b0 || unf8 !== 1'b0) begin n_fail++; $display("FAIL repl_flags got=%b%b exp=00", ovf8, unf8); end
    step(0, 0, 1, 0, '0);
    step(1, 1, 0, 0, 18'h00055);
    n_checks++; if (unf8 !== 1'b1 || cnt8 !== 4'd1 || wp8 !== 18'h00055) begin n_fail++; $display("FAIL repl_empty got=%b/%0d/%h exp=1/1/00055", unf8, cnt8, wp8); end
    step(0, 0, 1, 1, '0);
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 18'(16 * (i + 1)));
    n_checks++; if (cnt8 !== 4'd3) begin n_fail++; $display("FAIL fl_pre got=%0d exp=3", cnt8); end
    step(1, 0, 1, 0, 18'h00777);
    n_checks++; if (cnt8 !== 4'd0 || emp8 !== 1'b1) begin n_fail++; $display("FAIL flush_push got=%0d/%b exp=0/1", cnt8, emp8); end
    step(1, 0, 0, 0, 18'h00001);
    step(1, 0, 0, 0, 18'h00002);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (cnt8 !== 4'd0 || emp8 !== 1'b1 || wp8 !== 18'h0) begin n_fail++; $display("FAIL async_rst got=%0d/%b/%h exp=0/1/0", cnt8, emp8, wp8); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
